gene_net_driver: RTL and testbench

- Upstream stimulus stage for the gene-network cycle detector.
- Sweeps initial 8-gene states from FIRST_VAL to LAST_VAL. For each initial state it iterates the synchronous Boolean update rule once per clock, driving x, cnt and init_val_chk into the detector.
- Consumes the detector's registered flag and emits one result record per initial state: converged or timed out, plus the step count.

---
 rtl/gene_net_pkg.sv | 12 +
 rtl/gene_net_step.sv | 9 +
 rtl/gene_net_driver.sv | 117 +++++++++++
 tb/tb_gene_net_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gene_net_pkg.sv
// gene_net_pkg: shared constants, FSM state type and the gene update rule
package gene_net_pkg;
    localparam int N_GENES = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, REPORT, DONE} state_t;

    // Each gene turns on only when both ring neighbours are on
    function automatic logic [N_GENES-1:0] gene_next(input logic [N_GENES-1:0] x);
        return {x[N_GENES-2:0], x[N_GENES-1]} & {x[0], x[N_GENES-1:1]};
    endfunction
endpackage

// File: rtl/gene_net_step.sv
// gene_net_step: one synchronous update of the gene network, kept apart so the rule can be swapped
module gene_net_step
    import gene_net_pkg::*;
(
    input  logic [N_GENES-1:0] i_x,
    output logic [N_GENES-1:0] o_x_next
);
    assign o_x_next = gene_next(i_x);
endmodule

// File: rtl/gene_net_driver.sv
// gene_net_driver: sweeps initial gene states, iterates the network and reports convergence or timeout per state
module gene_net_driver
    import gene_net_pkg::*;
#(
    parameter logic [N_GENES-1:0] FIRST_VAL = 8'h00,
    parameter logic [N_GENES-1:0] LAST_VAL  = 8'hFF,
    parameter logic [CNT_W-1:0]   MAX_STEPS = 4'd15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flag,
    output logic [N_GENES-1:0] x,
    output logic [CNT_W-1:0]   cnt,
    output logic [N_GENES-1:0] init_val_chk,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    output logic [N_GENES-1:0] res_init,
    output logic               res_conv,
    output logic [CNT_W-1:0]   res_steps
);
    state_t               r_state;
    state_t               w_next_state;
    logic [N_GENES-1:0]   r_iv;
    logic [N_GENES-1:0]   r_x;
    logic [N_GENES-1:0]   r_ivc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_res_valid;
    logic [N_GENES-1:0]   r_res_init;
    logic                 r_res_conv;
    logic [CNT_W-1:0]     r_res_steps;
    logic [N_GENES-1:0]   w_x_next;
    logic                 w_conv;
    logic                 w_tmo;

    gene_net_step u_step (
        .i_x      (r_x),
        .o_x_next (w_x_next)
    );

    // The first four steps mask the flag: the detector history still holds the previous run
    assign w_conv = flag && (r_cnt >= CNT_W'(4));
    assign w_tmo  = (r_cnt == MAX_STEPS);

    // Next-state selection; convergence takes priority over timeout on the same edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = start ? LOAD : IDLE;
            LOAD:    w_next_state = RUN;
            RUN:     w_next_state = (w_conv || w_tmo) ? REPORT : RUN;
            REPORT:  w_next_state = (r_iv == LAST_VAL) ? DONE : LOAD;
            DONE:    w_next_state = start ? LOAD : DONE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register, network iteration, sweep index and result latching
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_iv        <= '0;
            r_x         <= '0;
            r_ivc       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_init  <= '0;
            r_res_conv  <= 1'b0;
            r_res_steps <= '0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state == LOAD) || (w_next_state == RUN) || (w_next_state == REPORT);
            r_done      <= (w_next_state == DONE);
            r_res_valid <= (w_next_state == REPORT);
            case (r_state)
                IDLE, DONE: begin
                    if (start) r_iv <= FIRST_VAL;
                end
                LOAD: begin
                    r_x   <= r_iv;
                    r_ivc <= r_iv;
                    r_cnt <= '0;
                end
                RUN: begin
                    if (w_next_state == REPORT) begin
                        r_res_init  <= r_iv;
                        r_res_conv  <= w_conv;
                        r_res_steps <= r_cnt;
                    end else begin
                        r_x   <= w_x_next;
                        r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (r_iv != LAST_VAL) r_iv <= r_iv + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign x            = r_x;
    assign cnt          = r_cnt;
    assign init_val_chk = r_ivc;
    assign busy         = r_busy;
    assign done         = r_done;
    assign res_valid    = r_res_valid;
    assign res_init     = r_res_init;
    assign res_conv     = r_res_conv;
    assign res_steps    = r_res_steps;
endmodule

// File: tb/tb_gene_net_driver.sv
// tb_gene_net_driver: full-sweep and corner-case bench with a detector model and a trajectory-based reference
module tb_gene_net_driver;
    import gene_net_pkg::*;

    typedef struct {
        logic [7:0] v;
        bit         conv;
        int         steps;
    } vec_t;

    bit clk = 0;
    bit rst = 1;
    bit start_a = 0;
    bit start_b = 0;
    int mode_b = 0;
    bit rec_en = 0;
    int n_pass = 0;
    int n_tot = 0;

    logic [7:0] x_a, ivc_a, ri_a, x_b, ivc_b, ri_b;
    logic [3:0] cnt_a, rs_a, cnt_b, rs_b;
    logic busy_a, done_a, rv_a, rc_a, busy_b, done_b, rv_b, rc_b;
    logic flag_a, flag_b;

    bit [7:0] da1, da2, db1, db2;
    bit fa, fb;
    logic [7:0] xs [256][16];
    bit   rc_arr [256];
    int   rs_arr [256];
    vec_t tbl [7];

    always #5 clk = ~clk;

    // Detector model: flag goes high one edge after x(t) == x(t-2)
    always @(posedge clk) begin
        da2 <= da1; da1 <= x_a; fa <= (x_a == da2);
        db2 <= db1; db1 <= x_b; fb <= (x_b == db2);
    end

    assign flag_a = fa;
    assign flag_b = (mode_b == 0) ? fb : (mode_b == 1) ? (cnt_b == 4'd2 || cnt_b == 4'd3) : (cnt_b == 4'd4);

    always @(negedge clk) if (rec_en && busy_a) xs[ivc_a][cnt_a] = x_a;

    gene_net_driver #(.FIRST_VAL(8'h00), .LAST_VAL(8'hFF), .MAX_STEPS(4'd15)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .flag(flag_a), .x(x_a), .cnt(cnt_a),
        .init_val_chk(ivc_a), .busy(busy_a), .done(done_a), .res_valid(rv_a),
        .res_init(ri_a), .res_conv(rc_a), .res_steps(rs_a));

    gene_net_driver #(.FIRST_VAL(8'h1F), .LAST_VAL(8'h1F), .MAX_STEPS(4'd4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .flag(flag_b), .x(x_b), .cnt(cnt_b),
        .init_val_chk(ivc_b), .busy(busy_b), .done(done_b), .res_valid(rv_b),
        .res_init(ri_b), .res_conv(rc_b), .res_steps(rs_b));

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: walk the trajectory; first step c>=4 with x(c-1)==x(c-3) converges, else timeout at mx
    function automatic void model(input logic [7:0] v, input int mx, output bit conv, output int steps);
        logic [7:0] s [16];
        s[0] = v;
        for (int c = 1; c < 16; c++) s[c] = gene_next(s[c-1]);
        conv = 0;
        steps = mx;
        for (int c = 4; c <= mx; c++)
            if (s[c-1] == s[c-3]) begin conv = 1; steps = c; return; end
    endfunction

    function automatic int trace_errs(input logic [7:0] v, input int steps);
        logic [7:0] s;
        int bad = 0;
        s = v;
        for (int c = 0; c <= steps; c++) begin
            if (xs[v][c] !== s) bad++;
            s = gene_next(s);
        end
        return bad;
    endfunction

    task automatic pulse(input bit b);
        @(negedge clk);
        if (b) start_b = 1; else start_a = 1;
        @(negedge clk);
        start_a = 0; start_b = 0;
    endtask

    task automatic wait_rv(input bit b, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (b ? rv_b : rv_a) begin ok = 1; return; end
        end
    endtask

    task automatic check_b(input string nm, input int conv, input int steps);
        bit ok;
        wait_rv(1, 100, ok);
        chk({nm, "_strobe"}, ok, 1);
        chk({nm, "_init"}, ri_b, 8'h1F);
        chk({nm, "_conv"}, rc_b, conv);
        chk({nm, "_steps"}, rs_b, steps);
        @(negedge clk);
        chk({nm, "_pulse_len"}, rv_b, 0);
        chk({nm, "_done"}, done_b, 1);
        chk({nm, "_hold_steps"}, rs_b, steps);
    endtask

    initial begin
        bit ok, mc;
        int ms, n, cyc, strobes;
        tbl[0] = '{8'h00, 1, 4};
        tbl[1] = '{8'h55, 1, 4};
        tbl[2] = '{8'hAA, 1, 4};
        tbl[3] = '{8'hFF, 1, 4};
        tbl[4] = '{8'h01, 1, 4};
        tbl[5] = '{8'h07, 1, 5};
        tbl[6] = '{8'h1F, 1, 6};

        repeat (2) @(negedge clk);
        chk("rst_x", x_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_valid", rv_a, 0);
        rst = 0;

        mode_b = 0;
        pulse(1);
        check_b("b_timeout", 0, 4);
        mode_b = 1;
        pulse(1);
        check_b("b_early_flag", 0, 4);
        mode_b = 2;
        pulse(1);
        check_b("b_flag_and_timeout", 1, 4);

        rec_en = 1;
        pulse(0);
        n = 0;
        cyc = 0;
        while (n < 256 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start_a = (cyc % 7 == 0);
            if (rv_a) begin
                chk("sweep_init", ri_a, n);
                model(8'(n), 15, mc, ms);
                chk("sweep_conv", rc_a, mc);
                chk("sweep_steps", rs_a, ms);
                chk("sweep_x_trace", trace_errs(8'(n), int'(rs_a)), 0);
                rc_arr[n] = rc_a;
                rs_arr[n] = rs_a;
                n++;
            end
        end
        start_a = 0;
        rec_en = 0;
        chk("sweep_count", n, 256);
        @(negedge clk);
        chk("sweep_done", done_a, 1);
        chk("sweep_busy_low", busy_a, 0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl_conv_%02h", tbl[i].v), rc_arr[tbl[i].v], tbl[i].conv);
            chk($sformatf("tbl_steps_%02h", tbl[i].v), rs_arr[tbl[i].v], tbl[i].steps);
        end

        pulse(0);
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = busy_a && ivc_a == 8'h10 && cnt_a == 4'd2;
        end
        chk("reach_run_10", ok, 1);
        #2 rst = 1;
        #1;
        chk("abort_x", x_a, 0);
        chk("abort_cnt", cnt_a, 0);
        chk("abort_ivc", ivc_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_res", {rv_a, ri_a, rc_a, rs_a}, 0);
        @(negedge clk);
        rst = 0;
        strobes = 0;
        repeat (40) begin
            @(negedge clk);
            if (rv_a) strobes++;
        end
        chk("no_strobe_after_abort", strobes, 0);
        chk("idle_after_abort", busy_a, 0);
        pulse(0);
        wait_rv(0, 100, ok);
        chk("restart_strobe", ok, 1);
        chk("restart_init", ri_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
